// File: rtl/parity_check_sched.sv
// Round-robin scheduler that time-shares one 3-input parity datapath among NREQ requesters.
// Each transaction runs IDLE->GRANT->DRIVE->SAMPLE->RESP, and mismatches feed a saturating counter.
module parity_check_sched #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [3*NREQ-1:0]  req_ops,
  input  logic [NREQ-1:0]    req_exp,
  output logic [NREQ-1:0]    gnt,
  output logic               chk_a,
  output logic               chk_b,
  output logic               chk_c,
  input  logic               chk_res,
  output logic               done,
  output logic [IDW-1:0]     done_id,
  output logic               done_res,
  output logic               done_err,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_DRIVE  = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Pointer holds the last winner; resetting it to NREQ-1 lets requester 0 win first.
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  logic [2:0]      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;
  logic [2:0]      lat_ops;
  logic            lat_exp;

  logic            any;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] win_oh;
  logic [2:0]      win_ops;
  logic            win_exp;
  logic            inc;

  // Rotating search starting just above the last winner.
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any && req[j] && (j == (int'(ptr) + 1 + i) % NREQ)) begin
          any = 1'b1;
          win = IDW'(j);
        end
      end
    end
  end

  always_comb begin
    win_oh  = '0;
    win_ops = '0;
    win_exp = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == win) begin
        win_oh[j] = 1'b1;
        win_ops   = req_ops[3*j +: 3];
        win_exp   = req_exp[j];
      end
    end
  end

  assign inc = (state == S_RESP) && done_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= PTR_RST;
      cur_id   <= '0;
      lat_ops  <= '0;
      lat_exp  <= 1'b0;
      gnt      <= '0;
      chk_a    <= 1'b0;
      chk_b    <= 1'b0;
      chk_c    <= 1'b0;
      done     <= 1'b0;
      done_id  <= '0;
      done_res <= 1'b0;
      done_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (any) begin
          state   <= S_GRANT;
          gnt     <= win_oh;
          ptr     <= win;
          cur_id  <= win;
          lat_ops <= win_ops;
          lat_exp <= win_exp;
        end
        S_GRANT: begin
          state <= S_DRIVE;
          {chk_a, chk_b, chk_c} <= lat_ops;
        end
        S_DRIVE:  state <= S_SAMPLE;
        S_SAMPLE: begin
          state    <= S_RESP;
          done     <= 1'b1;
          done_id  <= cur_id;
          done_res <= chk_res;
          done_err <= chk_res ^ lat_exp;
        end
        S_RESP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      // Clear wins over the old value, but a coincident mismatch still counts.
      if (err_clr)
        err_cnt <= inc ? CNT_W'(1) : '0;
      else if (inc && !(&err_cnt))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_check_sched.sv
// Directed bench for parity_check_sched: arbitration order, datapath sequencing, counter, reset abort.
module tb_parity_check_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_ops;
  logic [3:0]  req_exp;
  logic [3:0]  gnt;
  logic        chk_a, chk_b, chk_c, chk_res;
  logic        done;
  logic [1:0]  done_id;
  logic        done_res, done_err;
  logic        err_clr;
  logic [1:0]  err_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational checker under test.
  assign chk_res = chk_a ^ chk_b ^ chk_c;

  parity_check_sched #(.NREQ(4), .IDW(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ops(req_ops), .req_exp(req_exp),
    .gnt(gnt), .chk_a(chk_a), .chk_b(chk_b), .chk_c(chk_c), .chk_res(chk_res),
    .done(done), .done_id(done_id), .done_res(done_res), .done_err(done_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; operands are scrambled right after the grant.
  task automatic txn(input string tag, input logic [3:0] rm, input logic [11:0] ops,
                     input logic [3:0] ex, input int w, input logic eres, input logic eerr,
                     input logic [1:0] ecnt, input bit clr);
    logic [2:0] o;
    o = ops[3*w +: 3];
    req = rm; req_ops = ops; req_exp = ex;
    step();
    chk_eq({tag, ".gnt"}, 32'(gnt), 32'(1 << w));
    chk_eq({tag, ".done0"}, 32'(done), 32'(0));
    req = '0; req_ops = ~ops; req_exp = ~ex;
    step();
    chk_eq({tag, ".gnt_pulse"}, 32'(gnt), 32'(0));
    chk_eq({tag, ".drive"}, 32'({chk_a, chk_b, chk_c}), 32'(o));
    step();
    chk_eq({tag, ".sample"}, 32'({chk_a, chk_b, chk_c}), 32'(o));
    step();
    chk_eq({tag, ".done"}, 32'(done), 32'(1));
    chk_eq({tag, ".id"}, 32'(done_id), 32'(w));
    chk_eq({tag, ".res"}, 32'(done_res), 32'(eres));
    chk_eq({tag, ".err"}, 32'(done_err), 32'(eerr));
    chk_eq({tag, ".resp_ops"}, 32'({chk_a, chk_b, chk_c}), 32'(o));
    if (clr) err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_eq({tag, ".done_pulse"}, 32'(done), 32'(0));
    chk_eq({tag, ".cnt"}, 32'(err_cnt), 32'(ecnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last;
    logic [2:0] v;
    rst = 1'b1; req = '0; req_ops = '0; req_exp = '0; err_clr = 1'b0;
    step(); step();
    chk_eq("rst.gnt", 32'(gnt), 0);
    chk_eq("rst.chk", 32'({chk_a, chk_b, chk_c}), 0);
    chk_eq("rst.done", 32'({done, done_id, done_res, done_err}), 0);
    chk_eq("rst.cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    step();
    chk_eq("idle.gnt", 32'(gnt), 0);

    // Fairness: all requesters held high from reset.
    req = 4'hF; n = 0; last = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (gnt != '0) begin
        chk_eq("fair.gnt", 32'(gnt), 32'(1 << (n % 4)));
        if (n > 0) chk_eq("fair.gap", 32'(c - last), 32'(5));
        last = c;
        n++;
      end
    end
    req = '0;
    chk_eq("fair.count", 32'(n), 32'(6));
    repeat (4) step();

    // Single request, {a,b,c}=101 on requester 2.
    txn("single", 4'b0100, 12'h140, 4'b0000, 2, 1'b0, 1'b0, 2'd0, 1'b0);

    // All operand triples through requester 1.
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      txn("exh", 4'b0010, 12'(v) << 3, {2'b00, ^v, 1'b0}, 1, ^v, 1'b0, 2'd0, 1'b0);
    end

    // Operand stability (task scrambles ops after the grant).
    txn("stable", 4'b0001, 12'h006, 4'b0000, 0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Mismatches and saturation at CNT_W=2.
    txn("mis1", 4'b1000, 12'hE00, 4'b0000, 3, 1'b1, 1'b1, 2'd1, 1'b0);
    txn("mis2", 4'b1000, 12'hE00, 4'b0000, 3, 1'b1, 1'b1, 2'd2, 1'b0);
    txn("mis3", 4'b1000, 12'hE00, 4'b0000, 3, 1'b1, 1'b1, 2'd3, 1'b0);
    txn("sat",  4'b1000, 12'hE00, 4'b0000, 3, 1'b1, 1'b1, 2'd3, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_eq("clr.cnt", 32'(err_cnt), 0);
    txn("clr_inc", 4'b1000, 12'hE00, 4'b0000, 3, 1'b1, 1'b1, 2'd1, 1'b1);

    // Reset while in DRIVE, then pointer must be back at its reset value.
    req = 4'b0100; req_ops = 12'h1C0; req_exp = '0;
    step();
    chk_eq("abort.gnt", 32'(gnt), 32'(4'b0100));
    req = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("abort.gnt0", 32'(gnt), 0);
    chk_eq("abort.chk", 32'({chk_a, chk_b, chk_c}), 0);
    chk_eq("abort.done", 32'({done, done_id, done_res, done_err}), 0);
    chk_eq("abort.cnt", 32'(err_cnt), 0);
    n = 0;
    repeat (4) begin
      step();
      if (done) n++;
    end
    chk_eq("abort.nodone", 32'(n), 0);
    txn("abort.rr", 4'b1001, 12'h000, 4'b0000, 0, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_check_sched.md
Name: parity_check_sched

Overview:
- Round-robin scheduler that shares one 3-input XOR parity datapath (operands a/b/c, result res) among NREQ requesters.
- Each requester submits an operand triple plus its expected result. The scheduler sequences the operands onto the shared datapath, samples res, and returns a response tagged with the requester id and a mismatch flag.
- Keeps a saturating mismatch counter.
- Sits between testbench/APVM-driven stimulus agents and the combinational checker under test.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2**IDW >= NREQ.
- CNT_W, 16, width of mismatch counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request; held until granted.
- req_ops  in  3*NREQ  operands; requester i uses bits [3i+2:3i] = {a,b,c}.
- req_exp  in  NREQ  expected res per requester.
- gnt  out  NREQ  one-hot grant pulse, one cycle.
- chk_a  out  1  operand a to datapath.
- chk_b  out  1  operand b to datapath.
- chk_c  out  1  operand c to datapath.
- chk_res  in  1  datapath result, combinational from chk_a/b/c.
- done  out  1  response valid pulse, one cycle.
- done_id  out  IDW  requester id of response.
- done_res  out  1  sampled chk_res.
- done_err  out  1  done_res != expected.
- err_clr  in  1  clear mismatch counter.
- err_cnt  out  CNT_W  saturating mismatch count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; gnt=0; chk_a/b/c=0; done=0; done_id=0; done_res=0; done_err=0; err_cnt=0. Priority pointer is set so requester 0 wins first.
- FSM states: IDLE -> GRANT -> DRIVE -> SAMPLE -> RESP -> IDLE.
  - IDLE: if any req bit is high at a clock edge, go to GRANT; otherwise stay.
  - GRANT (1 cycle):
    - gnt[w]=1, where w is the first requester with req high, searching upward from (last winner + 1) mod NREQ.
    - Latch req_ops[w] and req_exp[w] at entry, i.e. the same edge that leaves IDLE.
    - Update the pointer to w.
  - DRIVE (1 cycle): chk_a/b/c = latched operands. This cycle lets the datapath settle.
  - SAMPLE (1 cycle): chk_a/b/c held. Register chk_res at the end of the cycle.
  - RESP (1 cycle):
    - done=1; done_id=w; done_res=sampled value; done_err = sampled ^ latched expected.
    - chk_a/b/c are still held.
    - done_res, done_err and done_id hold their values until the next RESP.
    - The next state is always IDLE.
- Timing: req seen high at edge k -> gnt high in cycle k..k+1, done high 3 cycles after gnt. One transaction per 5 cycles at most.
- Requester handshake:
  - The requester may drop req in the cycle after gnt.
  - If req is still high in IDLE, it is re-arbitrated. Round-robin places it last among the active requesters.
  - Operand or req changes after the latch edge do not affect an in-flight transaction.
  - req bits outside the NREQ range do not exist. gnt is never asserted for a requester whose req was low at the latch edge.
- Mismatch counter:
  - err_cnt increments by 1 on each RESP with done_err=1.
  - It saturates at 2**CNT_W-1 and does not wrap.
  - err_clr=1 sets the counter to 0. If err_clr coincides with an incrementing RESP, the result is 1 (clear applies first, then the count).
- Reset mid-transaction: return to IDLE with all outputs at reset values. No done is produced for the aborted request. The pointer returns to its reset value.
- All outputs are registered. There is no combinational path from req to gnt or from chk_res to done.

Test Plan:
1. Single request: req[2]=1, ops{a,b,c}=3'b101, exp=0 -> gnt[2] one cycle; chk_a/b/c=1/0/1 for 3 cycles; done 3 cycles after gnt with done_id=2, done_res=0, done_err=0; err_cnt stays 0.
2. Mismatch and saturation: CNT_W=2. Four requests with ops=3'b111 and exp=0 (res=1) -> done_err=1 each time; err_cnt reads 1,2,3,3. Then err_clr -> 0. err_clr together with a mismatching RESP -> 1.
3. Fairness: all 4 req held high -> grant order 0,1,2,3,0,1. Grants are spaced 5 cycles apart, and gnt is always one-hot.
4. Exhaustive datapath: requester 1 submits all 8 operand triples with exp=a^b^c -> 8 responses with done_res matching parity, done_err=0.
5. Operand stability: change req_ops[0] in the cycle after gnt[0] -> chk_a/b/c and done_res reflect the originally latched value.
6. Reset in DRIVE: assert rst for 1 cycle while in DRIVE -> no done. All outputs are 0 the next cycle. A subsequent request from requester 3 with requester 0 also requesting -> requester 0 is granted first.
